// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: game FSM, tick generator, LFSR spawner,
// per-hole mole lifetimes and hit judging for the 3x3 board.
module mole_scheduler #(
    parameter int unsigned TICK_DIV    = 10_000_000,
    parameter int unsigned UP_TICKS    = 15,
    parameter int unsigned SPAWN_TICKS = 8,
    parameter int unsigned GAME_TICKS  = 200,
    parameter int unsigned MAX_ACTIVE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic [3:0] hit_pos,
    output logic [8:0] mole_mask,
    output logic [7:0] score,
    output logic [7:0] miss,
    output logic [7:0] time_left,
    output logic       playing,
    output logic       game_over
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam int unsigned LW = $clog2(UP_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] spawn_cnt;
    logic [LW-1:0] life [9];
    logic [7:0]    lfsr;

    logic       tick;
    logic       end_tick;
    logic       spawn;
    logic       hit_ok;
    logic       wrong;
    logic       free_found;
    logic [8:0] hit_vec;
    logic [8:0] expire;
    logic [8:0] spawn_vec;
    logic [8:0] mask_n;
    logic [3:0] pick;
    logic [3:0] target;
    logic [4:0] cand;
    logic [3:0] active_cnt;
    logic [3:0] escape_cnt;
    logic [7:0] score_n;
    logic [7:0] miss_n;
    logic [9:0] miss_sum;

    // Per-cycle game events: tick, hit judging, expiries, spawn target, next counters
    always_comb begin
        tick     = (state == RUN) && (tick_cnt == TW'(TICK_DIV - 1));
        end_tick = tick && (time_left == 8'd1);
        hit_ok   = (state == RUN) && hit && (hit_pos <= 4'd8);
        hit_vec  = hit_ok ? (9'd1 << hit_pos) : '0;
        wrong    = |(hit_vec & ~mole_mask);

        // A hit on a mole whose life runs out this tick wins over the escape
        expire     = '0;
        active_cnt = '0;
        escape_cnt = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            expire[i]  = tick && mole_mask[i] && (life[i] == LW'(1)) && !hit_vec[i];
            active_cnt = active_cnt + 4'(mole_mask[i]);
            escape_cnt = escape_cnt + 4'(expire[i]);
        end

        // First free hole at or after the random pick, wrapping 8 -> 0
        pick       = 4'(lfsr % 8'd9);
        free_found = 1'b0;
        target     = '0;
        cand       = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            cand = 5'(pick) + 5'(k);
            if (cand >= 5'd9) begin
                cand = cand - 5'd9;
            end
            if (!free_found && !mole_mask[cand]) begin
                free_found = 1'b1;
                target     = 4'(cand);
            end
        end

        spawn = tick && !end_tick && (spawn_cnt == SW'(SPAWN_TICKS - 1))
                && (active_cnt < 4'(MAX_ACTIVE)) && free_found;
        spawn_vec = spawn ? (9'd1 << target) : '0;
        mask_n    = (mole_mask & ~expire & ~hit_vec) | spawn_vec;

        score_n  = (|(hit_vec & mole_mask) && (score != 8'hFF)) ? score + 8'd1 : score;
        miss_sum = 10'(miss) + 10'(wrong) + 10'(escape_cnt);
        miss_n   = (miss_sum > 10'd255) ? 8'hFF : miss_sum[7:0];
    end

    // Game FSM with registered outputs, counters, lifetimes and the LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            playing   <= 1'b0;
            game_over <= 1'b0;
            mole_mask <= '0;
            score     <= '0;
            miss      <= '0;
            time_left <= '0;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            lfsr      <= 8'hA5;
            for (int unsigned i = 0; i < 9; i++) begin
                life[i] <= '0;
            end
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= RUN;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                        mole_mask <= '0;
                        score     <= '0;
                        miss      <= '0;
                        time_left <= 8'(GAME_TICKS);
                        tick_cnt  <= '0;
                        spawn_cnt <= '0;
                        for (int unsigned i = 0; i < 9; i++) begin
                            life[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    mole_mask <= end_tick ? '0 : mask_n;
                    score     <= score_n;
                    miss      <= miss_n;
                    tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        time_left <= time_left - 8'd1;
                        spawn_cnt <= (spawn_cnt == SW'(SPAWN_TICKS - 1)) ? '0 : spawn_cnt + SW'(1);
                    end
                    for (int unsigned i = 0; i < 9; i++) begin
                        if (spawn_vec[i]) begin
                            life[i] <= LW'(UP_TICKS);
                        end else if (tick && mole_mask[i]) begin
                            life[i] <= life[i] - LW'(1);
                        end
                    end
                    if (end_tick) begin
                        state     <= OVER;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
